ram_bist_sequencer: RTL

//  Parametrised two-bank RAM self-test sequencer. A start pulse runs four phases: FILL, VERIFY1, COPY and VERIFY2.

---
 rtl/ram_bist_sequencer_if.sv | 23 ++
 rtl/ram_bist_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_sequencer_if.sv
// RAM controller request/acknowledge bus between the BIST sequencer and the RAM.
interface ram_bist_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic              mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_bank, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_bank, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/ram_bist_sequencer.sv
// Two-bank RAM self-test sequencer: FILL bank0, VERIFY bank0, COPY bank0+OFFSET
// into bank1, VERIFY bank1. Counts mismatches, captures the first failing
// {bank,addr} and aborts with a timeout if the controller stops acknowledging.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// FILL  | write seed+idx to bank0
// VER1  | read bank0, compare with seed+idx
// CP_RD | read bank0, keep rdata+OFFSET
// CP_WR | write kept value to bank1
// VER2  | read bank1, compare with seed+idx+OFFSET
// DONE  | one cycle; next edge pulses done, drops busy, sets pass
module ram_bist_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 10,
  parameter int OFFSET    = -1,
  parameter int TIMEOUT   = 255,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [DATA_W-1:0]    seed,
  ram_bist_sequencer_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [ADDR_W:0]      fail_addr,
  output logic [3:0]           phase
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_VER1  = 3'd2;
  localparam logic [2:0] S_CP_RD = 3'd3;
  localparam logic [2:0] S_CP_WR = 3'd4;
  localparam logic [2:0] S_VER2  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int               TMR_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(BURST_LEN - 1);
  localparam logic [DATA_W-1:0] OFF_V    = DATA_W'(OFFSET);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] cp_data;
  logic [TMR_W-1:0]  tmr;
  logic              req_q;
  logic              we_q;
  logic              bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] chk_data;
  logic              iss_we;
  logic              iss_bank;
  logic [DATA_W-1:0] iss_wdata;
  logic [2:0]        next_phase;
  logic              acked;
  logic              mismatch;
  logic              is_last;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_bank  = bank_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign phase         = {1'b0, state};

  assign cur_addr = base_q + idx;
  assign exp_data = seed_q + DATA_W'(idx);
  assign chk_data = (state == S_VER2) ? exp_data + OFF_V : exp_data;
  assign acked    = req_q && mem.mem_ack;
  assign is_last  = (idx == IDX_LAST);
  assign mismatch = acked && ((state == S_VER1) || (state == S_VER2)) &&
                    (mem.mem_rdata != chk_data);

  // Access attributes for the state's next request and the phase that follows it.
  always_comb begin
    iss_we     = 1'b0;
    iss_bank   = 1'b0;
    iss_wdata  = '0;
    next_phase = S_IDLE;
    case (state)
      S_FILL: begin
        iss_we     = 1'b1;
        iss_wdata  = exp_data;
        next_phase = S_VER1;
      end
      S_VER1:  next_phase = S_CP_RD;
      S_CP_RD: next_phase = S_CP_WR;
      S_CP_WR: begin
        iss_we     = 1'b1;
        iss_bank   = 1'b1;
        iss_wdata  = cp_data;
        next_phase = S_VER2;
      end
      S_VER2: begin
        iss_bank   = 1'b1;
        next_phase = S_DONE;
      end
      default: next_phase = S_IDLE;
    endcase
  end

  // Sequencer FSM, request handshake, per-request timer and result tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      cp_data   <= '0;
      tmr       <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      bank_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            seed_q    <= seed;
            idx       <= '0;
            err_cnt   <= '0;
            timeout   <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            busy      <= 1'b1;
            state     <= S_FILL;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_cnt == '0) && !timeout;
          state <= S_IDLE;
        end
        S_FILL, S_VER1, S_CP_RD, S_CP_WR, S_VER2: begin
          // req_q low here is always the idle gap after an ack or a state entry.
          if (!req_q) begin
            req_q   <= 1'b1;
            we_q    <= iss_we;
            bank_q  <= iss_bank;
            addr_q  <= cur_addr;
            wdata_q <= iss_wdata;
            tmr     <= TMR_LOAD;
          end else if (acked) begin
            req_q <= 1'b0;
            if (mismatch) begin
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
              if (err_cnt == '0) fail_addr <= {bank_q, addr_q};
            end
            if (state == S_CP_RD) begin
              cp_data <= mem.mem_rdata + OFF_V;
              state   <= S_CP_WR;
            end else if (is_last) begin
              idx   <= '0;
              state <= next_phase;
            end else begin
              idx <= idx + ADDR_W'(1);
              if (state == S_CP_WR) state <= S_CP_RD;
            end
          end else if (tmr == '0) begin
            req_q   <= 1'b0;
            timeout <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
